// File: rtl/uart_line_tx_queue.sv
// uart_line_tx_queue: queues 8-char reply lines and sends each as 8N1 UART, byte [7] first, skipping 00 bytes, then TERMINATOR
// Ports: clk; rst_n async active-low; i_start/i_data enqueue one line;
//        o_tx serial out (idle high); o_busy queue or transmitter active; o_full FIFO full;
//        o_drop one-cycle pulse per discarded line; o_drop_cnt saturating discard count.
module uart_line_tx_queue #(
  parameter int         UART_TX_CLK_DIV = 434,
  parameter int         FIFO_DEPTH      = 4,
  parameter logic [7:0] TERMINATOR      = 8'h0A
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [7:0][7:0] i_data,
  output logic            o_tx,
  output logic            o_busy,
  output logic            o_full,
  output logic            o_drop,
  output logic [7:0]      o_drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(UART_TX_CLK_DIV);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(UART_TX_CLK_DIV - 1);
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
  state_t          state_q;
  logic [7:0][7:0] mem_q [FIFO_DEPTH];
  logic [7:0][7:0] line_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic [CW-1:0]   bit_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [3:0]      byte_idx_q;
  logic [7:0]      shreg_q, cur;
  logic            pop, push, drop, bit_end;
  // pop looks at the registered count, so a line pushed into an empty FIFO waits one cycle
  always_comb begin
    pop = state_q == IDLE && count_q != '0;
    push = i_start && (count_q < DEPTH || pop);
    drop = i_start && !push;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    cur = byte_idx_q == 4'd0 ? TERMINATOR : line_q[3'(byte_idx_q - 4'd1)];
    bit_end = bit_cnt_q == BIT_LAST;
  end
  assign o_busy = count_q != '0 || state_q != IDLE;
  always_ff @(posedge clk) if (push) mem_q[wr_ptr_q] <= i_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      line_q <= '0;
      shreg_q <= '0;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      byte_idx_q <= '0;
      o_tx <= 1'b1;
      o_full <= 1'b0;
      o_drop <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      count_q <= count_d;
      o_full <= count_d == DEPTH;
      o_drop <= drop;
      o_drop_cnt <= o_drop_cnt + 8'(drop && o_drop_cnt != 8'hFF);
      bit_cnt_q <= bit_end ? '0 : bit_cnt_q + 1'b1;
      case (state_q)
        IDLE: if (pop) begin
          line_q <= mem_q[rd_ptr_q];
          byte_idx_q <= 4'd8;
          state_q <= LOAD;
        end
        // zero bytes cost one LOAD cycle each; the terminator (index 0) is always sent
        LOAD: if (byte_idx_q != 4'd0 && cur == 8'h00) byte_idx_q <= byte_idx_q - 4'd1;
        else begin
          shreg_q <= cur;
          o_tx <= 1'b0;
          bit_cnt_q <= '0;
          state_q <= START;
        end
        START: if (bit_end) begin
          o_tx <= shreg_q[0];
          shreg_q <= shreg_q >> 1;
          bit_idx_q <= '0;
          state_q <= DATA;
        end
        DATA: if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            o_tx <= 1'b1;
            state_q <= STOP;
          end else begin
            o_tx <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
            bit_idx_q <= bit_idx_q + 3'd1;
          end
        end
        STOP: if (bit_end) begin
          if (byte_idx_q == 4'd0) state_q <= IDLE;
          else begin
            byte_idx_q <= byte_idx_q - 4'd1;
            state_q <= LOAD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_line_tx_queue.sv
// tb_uart_line_tx_queue: directed and randomized checks of uart_line_tx_queue against a byte-stream model and a UART decoder
module tb_uart_line_tx_queue;
  localparam int DIV = 4;
  logic clk = 1'b0, rst_n = 1'b0, i_start = 1'b0;
  logic [7:0][7:0] i_data = '0;
  logic o_tx, o_busy, o_full, o_drop;
  logic [7:0] o_drop_cnt;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  int exp_drops = 0;
  logic [7:0] exp_q[$], rx_q[$];
  always #5 clk = ~clk;
  uart_line_tx_queue #(.UART_TX_CLK_DIV(DIV), .FIFO_DEPTH(4), .TERMINATOR(8'h0A)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_data(i_data), .o_tx(o_tx),
    .o_busy(o_busy), .o_full(o_full), .o_drop(o_drop), .o_drop_cnt(o_drop_cnt)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic void expect_line(input logic [7:0][7:0] d);
    for (int i = 7; i >= 0; i--) if (d[i] != 8'h00) exp_q.push_back(d[i]);
    exp_q.push_back(8'h0A);
  endfunction
  function automatic logic [63:0] rand_line(input bit allow_zero);
    logic [7:0][7:0] d;
    for (int i = 0; i < 8; i++)
      d[i] = (allow_zero && $urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    return d;
  endfunction
  function automatic logic frame_ok(input logic [10*DIV-1:0] b);
    logic ok;
    ok = !b[0] && b[9*DIV];
    for (int g = 0; g < 10; g++)
      for (int s = 1; s < DIV; s++) if (b[g*DIV+s] !== b[g*DIV]) ok = 1'b0;
    return ok;
  endfunction
  task automatic compare_stream(input string tag);
    check({tag, "_len"}, 64'(rx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) check(tag, rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask
  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (o_busy && n < bound) begin
      tick;
      n++;
    end
    check("idle_timeout", o_busy, 0);
    repeat (2) tick;
  endtask
  // UART receiver: samples every clock on the falling edge, requires each bit to be DIV clocks wide
  initial begin
    logic [10*DIV-1:0] bits;
    logic [7:0] b;
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) n = 0;
      else if (n != 0 || !o_tx) begin
        bits[n] = o_tx;
        n++;
        if (n == 10 * DIV) begin
          n = 0;
          check("frame", frame_ok(bits), 1);
          for (int i = 0; i < 8; i++) b[i] = bits[(i+1)*DIV];
          rx_q.push_back(b);
        end
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int nb;
    repeat (5) tick;
    check("rst_tx", o_tx, 1);
    check("rst_busy", o_busy, 0);
    check("rst_full", o_full, 0);
    check("rst_drop", o_drop, 0);
    check("rst_drop_cnt", o_drop_cnt, 0);
    rst_n = 1'b1;
    tick;
    i_start = 1'b1;
    i_data = 64'h7273_7420_646F_6E65;
    expect_line(i_data);
    tick;
    i_start = 1'b0;
    check("lat_e0", o_tx, 1);
    check("busy_e0", o_busy, 1);
    tick;
    check("lat_e1", o_tx, 1);
    tick;
    check("lat_e2", o_tx, 0);
    repeat (367) tick;
    check("busy_e369", o_busy, 1);
    tick;
    check("busy_e370", o_busy, 0);
    repeat (2) tick;
    compare_stream("rst_done");
    i_start = 1'b1;
    i_data = 64'h41;
    expect_line(i_data);
    tick;
    i_start = 1'b0;
    wait_idle(1000);
    compare_stream("zskip_41");
    i_start = 1'b1;
    i_data = 64'h0;
    expect_line(i_data);
    tick;
    i_start = 1'b0;
    wait_idle(1000);
    compare_stream("zskip_00");
    for (int r = 0; r < 6; r++) begin
      nb = $urandom_range(1, 5);
      for (int k = 0; k < nb; k++) begin
        i_start = 1'b1;
        i_data = rand_line(1);
        expect_line(i_data);
        tick;
      end
      i_start = 1'b0;
      check("rnd_nodrop", o_drop_cnt, exp_drops);
      wait_idle(3000);
      compare_stream("rand");
    end
    for (int k = 0; k < 6; k++) begin
      i_start = 1'b1;
      i_data = rand_line(0);
      if (k < 5) expect_line(i_data);
      tick;
      check("ovf_full", o_full, k >= 4);
      check("ovf_drop", o_drop, k == 5);
    end
    i_start = 1'b0;
    tick;
    exp_drops = 1;
    check("ovf_drop_clr", o_drop, 0);
    check("ovf_cnt", o_drop_cnt, exp_drops);
    check("ovf_full_hold", o_full, 1);
    repeat (364) tick;
    check("ovf_full_e370", o_full, 1);
    tick;
    check("ovf_full_e371", o_full, 0);
    wait_idle(3000);
    compare_stream("ovf");
    for (int k = 0; k < 5; k++) begin
      i_start = 1'b1;
      i_data = rand_line(0);
      expect_line(i_data);
      tick;
    end
    i_start = 1'b0;
    repeat (366) tick;
    check("pp_full_pre", o_full, 1);
    i_start = 1'b1;
    i_data = rand_line(0);
    expect_line(i_data);
    tick;
    check("pp_drop", o_drop, 0);
    check("pp_full", o_full, 1);
    i_data = rand_line(0);
    tick;
    i_start = 1'b0;
    exp_drops++;
    check("pp_drop_next", o_drop, 1);
    check("pp_cnt", o_drop_cnt, exp_drops);
    wait_idle(3000);
    compare_stream("pushpop");
    for (int k = 0; k < 5; k++) begin
      i_start = 1'b1;
      i_data = rand_line(0);
      expect_line(i_data);
      tick;
    end
    repeat (260) begin
      i_data = {$urandom, $urandom};
      tick;
    end
    i_start = 1'b0;
    exp_drops = (exp_drops + 260 > 255) ? 255 : exp_drops + 260;
    check("sat_cnt", o_drop_cnt, exp_drops);
    wait_idle(3000);
    compare_stream("sat");
    i_start = 1'b1;
    i_data = 64'h6162_4143_4445_4647;
    tick;
    i_data = rand_line(0);
    tick;
    i_data = rand_line(0);
    tick;
    i_start = 1'b0;
    repeat (98) tick;
    check("pre_rst_tx", o_tx, 0);
    rst_n = 1'b0;
    #1;
    check("arst_tx", o_tx, 1);
    check("arst_busy", o_busy, 0);
    check("arst_full", o_full, 0);
    check("arst_drop_cnt", o_drop_cnt, 0);
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h62);
    repeat (3) tick;
    rst_n = 1'b1;
    compare_stream("trunc");
    tick;
    i_start = 1'b1;
    i_data = rand_line(1);
    expect_line(i_data);
    tick;
    i_start = 1'b0;
    wait_idle(1000);
    compare_stream("post_rst");
    check("post_rst_drops", o_drop_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
